// File: rtl/ivs_dma_pkg.sv
// Shared types and constants for the write-DMA scheduler.
// Holds the FSM state encoding and the bus geometry constants.
package ivs_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_AW   = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int PAGE_BYTES = 4096;
    localparam int BEAT_BYTES = 16;
    localparam int MAX_BURST  = 64;

endpackage

// File: rtl/ivs_dma_wr_sched_if.sv
// AXI write address/data control signals shared by the scheduler and the bus.
// Handshake: a transfer happens on a clock edge where valid && ready; the source holds its payload stable while valid && !ready.
interface ivs_dma_wr_sched_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [5:0]  awlen;
    logic        wvalid_in;
    logic        wready;
    logic        wlast;

    modport master (
        output awvalid, awaddr, awlen, wlast,
        input  awready, wvalid_in, wready
    );

    modport slave (
        input  awvalid, awaddr, awlen, wlast,
        output awready, wvalid_in, wready
    );
endinterface

// File: rtl/ivs_rr_arb.sv
// Round-robin picker: grants the first request at or after the pointer.
// The pointer moves to one past the served index on each advance pulse.
module ivs_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    input  logic [IDX_W-1:0]   adv_idx,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);
    logic [IDX_W-1:0] ptr;
    logic             found;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx + IDX_W'(1);
        end
    end

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end
endmodule

// File: rtl/ivs_dma_wr_sched.sv
// Write-DMA scheduler: round-robin shares one AXI AW/W channel pair between
// requesters, splitting each transfer into bursts bounded by length and 4 KB pages.
module ivs_dma_wr_sched #(
    parameter int NUM_REQ    = 2,
    parameter int MAX_BURST  = ivs_dma_pkg::MAX_BURST,
    parameter int BEAT_BYTES = ivs_dma_pkg::BEAT_BYTES,
    parameter int LEN_W      = 32
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*32-1:0]    base,
    input  logic [NUM_REQ*LEN_W-1:0] len,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output ivs_dma_pkg::state_t      dbg_state,
    ivs_dma_wr_sched_if.master       axi
);
    import ivs_dma_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx, gidx;
    logic [31:0]        cur_addr, sel_base;
    logic [LEN_W-1:0]   remain, sel_len;
    logic [5:0]         beat_cnt, blen;
    logic [6:0]         bmax;
    logic [12:0]        page_beats;
    logic               w_hs, last_beat;

    ivs_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .clk     (aclk),
        .rst     (arst),
        .req     (req),
        .adv     (state == ST_DONE),
        .adv_idx (gidx),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    assign sel_base  = base[int'(arb_idx)*32 +: 32];
    assign sel_len   = len[int'(arb_idx)*LEN_W +: LEN_W];
    assign w_hs      = axi.wvalid_in && axi.wready;
    assign last_beat = (beat_cnt == blen);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Burst size: smallest of remaining beats, the burst cap and beats left in the page.
    always_comb begin
        page_beats = 13'((PAGE_BYTES - int'(cur_addr[11:0])) / BEAT_BYTES);
        bmax       = 7'(MAX_BURST);
        if (remain < LEN_W'(MAX_BURST)) bmax = 7'(remain);
        if (page_beats < 13'(bmax))     bmax = 7'(page_beats);
    end

    always_comb begin
        state_nxt   = state;
        ack         = '0;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.awlen   = blen;
        axi.wlast   = 1'b0;
        case (state)
            ST_IDLE: if (|req) state_nxt = ST_ARB;
            ST_ARB: begin
                if (!(|req))              state_nxt = ST_IDLE;
                else if (sel_len == '0)   state_nxt = ST_DONE;
                else                      state_nxt = ST_AW;
            end
            ST_AW: begin
                axi.awvalid = 1'b1;
                axi.awaddr  = cur_addr;
                axi.awlen   = 6'(bmax - 7'd1);
                if (axi.awready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                axi.wlast = last_beat;
                if (w_hs && last_beat) begin
                    state_nxt = (remain == LEN_W'(blen) + LEN_W'(1)) ? ST_DONE : ST_AW;
                end
            end
            ST_DONE: begin
                ack       = grant;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            gidx     <= '0;
            cur_addr <= '0;
            remain   <= '0;
            beat_cnt <= '0;
            blen     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_ARB: begin
                    grant    <= arb_gnt;
                    gidx     <= arb_idx;
                    cur_addr <= {sel_base[31:4], 4'b0000};
                    remain   <= sel_len;
                end
                ST_AW: begin
                    if (axi.awready) begin
                        blen     <= 6'(bmax - 7'd1);
                        beat_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            cur_addr <= cur_addr + 32'((32'(blen) + 32'd1) * 32'(BEAT_BYTES));
                            remain   <= remain - (LEN_W'(blen) + LEN_W'(1));
                        end else begin
                            beat_cnt <= beat_cnt + 6'd1;
                        end
                    end
                end
                ST_DONE: grant <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ivs_dma_wr_sched.sv
// Directed bench for ivs_dma_wr_sched: burst splitting, page boundary,
// round-robin order, back-pressure, zero length and mid-transfer reset.
module tb_ivs_dma_wr_sched;
    import ivs_dma_pkg::*;

    logic        aclk;
    logic        arst;
    logic [1:0]  req;
    logic [63:0] base;
    logic [63:0] len;
    logic [1:0]  ack;
    logic [1:0]  grant;
    logic        busy;
    state_t      dbg_state;
    int          total;
    int          bad;

    ivs_dma_wr_sched_if axi_if ();

    ivs_dma_wr_sched #(.NUM_REQ(2), .MAX_BURST(64), .BEAT_BYTES(16), .LEN_W(32)) dut (
        .aclk      (aclk),
        .arst      (arst),
        .req       (req),
        .base      (base),
        .len       (len),
        .ack       (ack),
        .grant     (grant),
        .busy      (busy),
        .dbg_state (dbg_state),
        .axi       (axi_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Plays the bus side of one burst and reports what was observed.
    task automatic run_burst(input int aw_stall, input bit toggle_w,
                             output logic [31:0] a, output logic [5:0] l,
                             output int nbeats, output bit wlast_err,
                             output bit unstable, output bit aw_stuck, output bit tmo);
        int n;
        a = '0; l = '0; nbeats = 0; wlast_err = 0; unstable = 0; aw_stuck = 0; tmo = 0;
        n = 0;
        while (axi_if.awvalid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (axi_if.awvalid !== 1'b1) begin
            tmo = 1;
            return;
        end
        a = axi_if.awaddr;
        l = axi_if.awlen;
        for (int i = 0; i < aw_stall; i++) begin
            step();
            if (axi_if.awvalid !== 1'b1 || axi_if.awaddr !== a || axi_if.awlen !== l) unstable = 1;
        end
        axi_if.awready = 1'b1;
        step();
        axi_if.awready = 1'b0;
        if (axi_if.awvalid !== 1'b0) aw_stuck = 1;
        n = 0;
        while (n < 300) begin
            if (toggle_w) begin
                axi_if.wvalid_in = (n % 3 != 1);
                axi_if.wready    = (n % 3 != 0);
            end else begin
                axi_if.wvalid_in = 1'b1;
                axi_if.wready    = 1'b1;
            end
            if (axi_if.wlast !== (nbeats == int'(l))) wlast_err = 1;
            step();
            n++;
            if (axi_if.wvalid_in && axi_if.wready) begin
                nbeats++;
                if (nbeats == int'(l) + 1) break;
            end
        end
        if (n >= 300) tmo = 1;
        axi_if.wvalid_in = 1'b0;
        axi_if.wready    = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        step();
        step();
        total++;
        if (ack !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got ack=%b grant=%b busy=%b exp 00 00 0", ack, grant, busy);
        end
        total++;
        if (axi_if.awvalid !== 1'b0 || axi_if.awaddr !== 32'h0 || axi_if.awlen !== 6'd0 || axi_if.wlast !== 1'b0) begin
            bad++;
            $display("FAIL reset_bus got awvalid=%b awaddr=%h awlen=%0d wlast=%b exp all zero",
                     axi_if.awvalid, axi_if.awaddr, axi_if.awlen, axi_if.wlast);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        end
        arst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [31:0] a; logic [5:0] l; int nb; bit we, us, st, tmo;
        base[31:0] = 32'h0000_1000;
        len[31:0]  = 32'd4;
        req = 2'b01;
        run_burst(0, 0, a, l, nb, we, us, st, tmo);
        total++;
        if (tmo !== 1'b0 || a !== 32'h1000 || l !== 6'd3) begin
            bad++;
            $display("FAIL single_aw got tmo=%b awaddr=%h awlen=%0d exp 0 1000 3", tmo, a, l);
        end
        total++;
        if (nb !== 4 || we !== 1'b0 || st !== 1'b0) begin
            bad++;
            $display("FAIL single_w got beats=%0d wlast_err=%b aw_stuck=%b exp 4 0 0", nb, we, st);
        end
        total++;
        if (ack !== 2'b01 || grant !== 2'b01) begin
            bad++;
            $display("FAIL single_ack got ack=%b grant=%b exp 01 01", ack, grant);
        end
        req = 2'b00;
        step();
        total++;
        if (ack !== 2'b00 || grant !== 2'b00) begin
            bad++;
            $display("FAIL single_ack_pulse got ack=%b grant=%b exp 00 00", ack, grant);
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_split();
        logic [31:0] a; logic [5:0] l; int nb; bit we, us, st, tmo;
        logic [31:0] ea [3];
        logic [5:0]  el [3];
        ea = '{32'h000, 32'h400, 32'h800};
        el = '{6'd63, 6'd63, 6'd1};
        base[63:32] = 32'h0;
        len[63:32]  = 32'd130;
        req = 2'b10;
        for (int i = 0; i < 3; i++) begin
            run_burst(0, 0, a, l, nb, we, us, st, tmo);
            total++;
            if (tmo !== 1'b0 || a !== ea[i] || l !== el[i] || nb !== int'(el[i]) + 1 || we !== 1'b0) begin
                bad++;
                $display("FAIL split_burst%0d got tmo=%b awaddr=%h awlen=%0d beats=%0d wlast_err=%b exp awaddr=%h awlen=%0d",
                         i, tmo, a, l, nb, we, ea[i], el[i]);
            end
            if (i < 2) begin
                total++;
                if (ack !== 2'b00 || grant !== 2'b10) begin
                    bad++;
                    $display("FAIL split_mid%0d got ack=%b grant=%b exp 00 10", i, ack, grant);
                end
            end
        end
        total++;
        if (ack !== 2'b10) begin
            bad++;
            $display("FAIL split_ack got=%b exp=10", ack);
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_page();
        logic [31:0] a; logic [5:0] l; int nb; bit we, us, st, tmo;
        base[31:0] = 32'h0000_0FC5;
        len[31:0]  = 32'd8;
        req = 2'b01;
        run_burst(0, 0, a, l, nb, we, us, st, tmo);
        total++;
        if (tmo !== 1'b0 || a !== 32'hFC0 || l !== 6'd3 || nb !== 4) begin
            bad++;
            $display("FAIL page_first got tmo=%b awaddr=%h awlen=%0d beats=%0d exp 0 fc0 3 4", tmo, a, l, nb);
        end
        run_burst(0, 0, a, l, nb, we, us, st, tmo);
        total++;
        if (tmo !== 1'b0 || a !== 32'h1000 || l !== 6'd3 || nb !== 4) begin
            bad++;
            $display("FAIL page_second got tmo=%b awaddr=%h awlen=%0d beats=%0d exp 0 1000 3 4", tmo, a, l, nb);
        end
        total++;
        if (ack !== 2'b01) begin
            bad++;
            $display("FAIL page_ack got=%b exp=01", ack);
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic [31:0] a; logic [5:0] l; int nb; bit we, us, st, tmo;
        logic [1:0]  eg [4];
        logic [1:0]  rn [4];
        logic [31:0] ea;
        eg = '{2'b01, 2'b10, 2'b01, 2'b10};
        rn = '{2'b10, 2'b11, 2'b10, 2'b00};
        arst = 1'b1;
        step();
        arst = 1'b0;
        base = {32'h0000_0200, 32'h0000_0100};
        len  = {32'd2, 32'd2};
        req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            run_burst(0, 0, a, l, nb, we, us, st, tmo);
            ea = (eg[k] == 2'b01) ? 32'h100 : 32'h200;
            total++;
            if (tmo !== 1'b0 || grant !== eg[k] || ack !== eg[k] || a !== ea || l !== 6'd1) begin
                bad++;
                $display("FAIL rr_round%0d got tmo=%b grant=%b ack=%b awaddr=%h awlen=%0d exp grant=%b awaddr=%h awlen=1",
                         k, tmo, grant, ack, a, l, eg[k], ea);
            end
            req = rn[k];
        end
        step();
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] a; logic [5:0] l; int nb; bit we, us, st, tmo;
        base[63:32] = 32'h0000_2000;
        len[63:32]  = 32'd3;
        req = 2'b10;
        run_burst(5, 1, a, l, nb, we, us, st, tmo);
        total++;
        if (tmo !== 1'b0 || us !== 1'b0 || a !== 32'h2000 || l !== 6'd2) begin
            bad++;
            $display("FAIL bp_aw got tmo=%b unstable=%b awaddr=%h awlen=%0d exp 0 0 2000 2", tmo, us, a, l);
        end
        total++;
        if (st !== 1'b0) begin
            bad++;
            $display("FAIL bp_aw_drop got aw_stuck=%b exp 0", st);
        end
        total++;
        if (nb !== 3 || we !== 1'b0) begin
            bad++;
            $display("FAIL bp_beats got beats=%0d wlast_err=%b exp 3 0", nb, we);
        end
        total++;
        if (ack !== 2'b10) begin
            bad++;
            $display("FAIL bp_ack got=%b exp=10", ack);
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_len0();
        bit seen_aw;
        int n;
        seen_aw = 0;
        base[31:0] = 32'h0000_5000;
        len[31:0]  = 32'd0;
        req = 2'b01;
        n = 0;
        while (ack === 2'b00 && n < 10) begin
            step();
            if (axi_if.awvalid !== 1'b0) seen_aw = 1;
            n++;
        end
        total++;
        if (ack !== 2'b01 || n !== 2) begin
            bad++;
            $display("FAIL len0_ack got ack=%b cycles=%0d exp 01 2", ack, n);
        end
        total++;
        if (seen_aw !== 1'b0) begin
            bad++;
            $display("FAIL len0_no_aw got awvalid_seen=%b exp 0", seen_aw);
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a; logic [5:0] l; int nb; bit we, us, st, tmo;
        bit ack_seen;
        int n;
        base[31:0] = 32'h0000_3000;
        len[31:0]  = 32'd8;
        req = 2'b01;
        n = 0;
        while (axi_if.awvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (axi_if.awvalid !== 1'b1 || axi_if.awlen !== 6'd7) begin
            bad++;
            $display("FAIL rmid_aw got awvalid=%b awlen=%0d exp 1 7", axi_if.awvalid, axi_if.awlen);
        end
        axi_if.awready = 1'b1;
        step();
        axi_if.awready   = 1'b0;
        axi_if.wvalid_in = 1'b1;
        axi_if.wready    = 1'b1;
        step();
        step();
        axi_if.wvalid_in = 1'b0;
        axi_if.wready    = 1'b0;
        arst = 1'b1;
        req  = 2'b00;
        step();
        arst = 1'b0;
        total++;
        if (axi_if.awvalid !== 1'b0 || grant !== 2'b00 || ack !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_after got awvalid=%b grant=%b ack=%b busy=%b exp 0 00 00 0",
                     axi_if.awvalid, grant, ack, busy);
        end
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ack !== 2'b00) ack_seen = 1;
        end
        total++;
        if (ack_seen !== 1'b0) begin
            bad++;
            $display("FAIL rmid_no_ack got ack_seen=%b exp 0", ack_seen);
        end
        base = {32'h0000_0080, 32'h0000_0040};
        len  = {32'd1, 32'd1};
        req  = 2'b11;
        run_burst(0, 0, a, l, nb, we, us, st, tmo);
        total++;
        if (tmo !== 1'b0 || a !== 32'h40 || l !== 6'd0 || nb !== 1 || grant !== 2'b01 || ack !== 2'b01) begin
            bad++;
            $display("FAIL rmid_restart got tmo=%b awaddr=%h awlen=%0d beats=%0d grant=%b ack=%b exp 0 40 0 1 01 01",
                     tmo, a, l, nb, grant, ack);
        end
        req = 2'b00;
        step();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        arst  = 1'b1;
        req   = 2'b00;
        base  = '0;
        len   = '0;
        axi_if.awready   = 1'b0;
        axi_if.wvalid_in = 1'b0;
        axi_if.wready    = 1'b0;
        test_reset();
        test_single();
        test_split();
        test_page();
        test_round_robin();
        test_backpressure();
        test_len0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
